// File: rtl/keypad_entry.sv
// Debounced keypad entry collector: qualifies one event per physical press and
// accumulates decimal digits into a left-shifting packed-BCD entry register.
module keypad_entry #(
    parameter int DIGITS          = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [3:0]                    i_key,
    input  logic                          i_key_detected,
    input  logic                          i_clear,
    output logic [4*DIGITS-1:0]           o_entry,
    output logic [$clog2(DIGITS+1)-1:0]   o_digit_count,
    output logic                          o_key_pulse,
    output logic [3:0]                    o_key_code,
    output logic                          o_entry_valid,
    output logic                          o_cmd_pulse,
    output logic                          o_busy
);

    localparam int CW = $clog2(DIGITS+1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES+1);
    localparam int EW = 4*DIGITS;
    localparam logic [CW-1:0] FULL    = CW'(DIGITS);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES-1);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

    state_t          r_state;
    logic [DW-1:0]   r_cnt;
    logic [3:0]      r_cand;
    logic [EW-1:0]   r_entry;
    logic [CW-1:0]   r_count;
    logic            r_key_pulse;
    logic [3:0]      r_key_code;
    logic            r_entry_valid;
    logic            r_cmd_pulse;
    logic            r_busy;

    logic            w_accept;
    logic [EW-1:0]   w_shl;
    logic [EW-1:0]   w_entry_next;
    logic [CW-1:0]   w_count_next;
    logic            w_full_now;

    generate
        if (DIGITS > 1) begin : g_shl
            assign w_shl = {r_entry[EW-5:0], r_cand};
        end else begin : g_shl_single
            assign w_shl = r_cand;
        end
    endgenerate

    // Acceptance happens on the edge that would bring the counter to DEBOUNCE_CYCLES.
    assign w_accept = (r_state == PRESS_DB) && i_key_detected &&
                      (i_key == r_cand) && (r_cnt == DB_LAST);

    always_comb begin
        w_entry_next = r_entry;
        w_count_next = r_count;
        w_full_now   = 1'b0;
        if (w_accept) begin
            if (r_cand <= 4'd9) begin
                if (r_count == FULL) begin
                    w_entry_next = EW'(r_cand);
                    w_count_next = CW'(1);
                end else begin
                    w_entry_next = w_shl;
                    w_count_next = r_count + CW'(1);
                    w_full_now   = (r_count + CW'(1) == FULL);
                end
            end else if (r_cand == 4'hE && r_count != '0 && r_count != FULL) begin
                w_entry_next = r_entry >> 4;
                w_count_next = r_count - CW'(1);
            end
        end
        // Clear overrides any entry change from a coincident acceptance.
        if (i_clear) begin
            w_entry_next = '0;
            w_count_next = '0;
            w_full_now   = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_cand        <= '0;
            r_entry       <= '0;
            r_count       <= '0;
            r_key_pulse   <= 1'b0;
            r_key_code    <= '0;
            r_entry_valid <= 1'b0;
            r_cmd_pulse   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_entry       <= w_entry_next;
            r_count       <= w_count_next;
            r_key_pulse   <= w_accept;
            r_entry_valid <= w_full_now;
            r_cmd_pulse   <= w_accept && (r_cand == 4'hF);
            if (w_accept) begin
                r_key_code <= r_cand;
            end

            case (r_state)
                IDLE: begin
                    if (i_key_detected) begin
                        r_cand  <= i_key;
                        r_cnt   <= DW'(1);
                        r_state <= PRESS_DB;
                        r_busy  <= 1'b1;
                    end
                end
                PRESS_DB: begin
                    if (!i_key_detected) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (i_key != r_cand) begin
                        r_cand <= i_key;
                        r_cnt  <= DW'(1);
                    end else begin
                        r_cnt <= r_cnt + DW'(1);
                        if (r_cnt == DB_LAST) begin
                            r_state <= HELD;
                        end
                    end
                end
                HELD: begin
                    if (!i_key_detected) begin
                        r_cnt   <= DW'(1);
                        r_state <= RELEASE_DB;
                    end
                end
                RELEASE_DB: begin
                    if (i_key_detected) begin
                        r_state <= HELD;
                    end else if (r_cnt == DB_LAST) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + DW'(1);
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_entry       = r_entry;
    assign o_digit_count = r_count;
    assign o_key_pulse   = r_key_pulse;
    assign o_key_code    = r_key_code;
    assign o_entry_valid = r_entry_valid;
    assign o_cmd_pulse   = r_cmd_pulse;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: table of presses with hand-derived expectations feeding
// a scoreboard that is drained whenever the DUT raises key_pulse.
module tb_keypad_entry;

    localparam int DB = 4;
    localparam int ND = 4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  key;
    logic        kd;
    logic        clr;
    logic [15:0] entry;
    logic [2:0]  dcount;
    logic        key_pulse;
    logic [3:0]  key_code;
    logic        entry_valid;
    logic        cmd_pulse;
    logic        busy;

    keypad_entry #(.DIGITS(ND), .DEBOUNCE_CYCLES(DB)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_key          (key),
        .i_key_detected (kd),
        .i_clear        (clr),
        .o_entry        (entry),
        .o_digit_count  (dcount),
        .o_key_pulse    (key_pulse),
        .o_key_code     (key_code),
        .o_entry_valid  (entry_valid),
        .o_cmd_pulse    (cmd_pulse),
        .o_busy         (busy)
    );

    typedef struct {
        logic [3:0]  key;
        logic [15:0] entry;
        logic [2:0]  count;
        logic        valid;
        logic        cmd;
    } vec_t;

    typedef struct {
        logic [3:0]  code;
        logic [15:0] entry;
        logic [2:0]  count;
        logic        valid;
        logic        cmd;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    logic prev_strobe = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Scoreboard drain and strobe-width checks, sampled on the falling edge.
    always @(negedge clk) begin
        if (prev_strobe)
            chk("strobes_one_cycle", {29'd0, key_pulse, entry_valid, cmd_pulse}, 32'd0);
        prev_strobe = key_pulse | entry_valid | cmd_pulse;
        if (key_pulse) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {31'd0, key_pulse}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                $display("press code=%h entry=%h count=%0d valid=%0b cmd=%0b cycle=%0d",
                         key_code, entry, dcount, entry_valid, cmd_pulse, cyc);
                chk("pulse_cycle", cyc, mon_e.cyc);
                chk("key_code", {28'd0, key_code}, {28'd0, mon_e.code});
                chk("entry", {16'd0, entry}, {16'd0, mon_e.entry});
                chk("digit_count", {29'd0, dcount}, {29'd0, mon_e.count});
                chk("entry_valid", {31'd0, entry_valid}, {31'd0, mon_e.valid});
                chk("cmd_pulse", {31'd0, cmd_pulse}, {31'd0, mon_e.cmd});
            end
        end else if (entry_valid || cmd_pulse) begin
            chk("orphan_strobe", {30'd0, entry_valid, cmd_pulse}, 32'd0);
        end
    end

    task automatic push_exp(input logic [3:0] k, input logic [15:0] e, input logic [2:0] c,
                            input logic v, input logic cm, input int at);
        exp_t x;
        x.code = k; x.entry = e; x.count = c; x.valid = v; x.cmd = cm; x.cyc = at;
        sb.push_back(x);
    endtask

    // Hold for 6 samples, release for 6; optionally raise clear on the accepting edge.
    task automatic press(input logic [3:0] k, input logic [15:0] e, input logic [2:0] c,
                         input logic v, input logic cm, input logic with_clear);
        @(negedge clk);
        key = k;
        kd  = 1'b1;
        push_exp(k, e, c, v, cm, cyc + DB);
        for (int i = 1; i < 6; i++) begin
            @(negedge clk);
            clr = with_clear && (i == DB - 1);
        end
        @(negedge clk);
        kd  = 1'b0;
        clr = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_entry"}, {16'd0, entry}, 32'd0);
        chk({tag, "_count"}, {29'd0, dcount}, 32'd0);
        chk({tag, "_code"}, {28'd0, key_code}, 32'd0);
        chk({tag, "_strobes"}, {29'd0, key_pulse, entry_valid, cmd_pulse}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    vec_t vecs[17];
    logic lv[7];

    initial begin
        vecs[0]  = '{4'h1, 16'h0001, 3'd1, 1'b0, 1'b0};
        vecs[1]  = '{4'h2, 16'h0012, 3'd2, 1'b0, 1'b0};
        vecs[2]  = '{4'h3, 16'h0123, 3'd3, 1'b0, 1'b0};
        vecs[3]  = '{4'h4, 16'h1234, 3'd4, 1'b1, 1'b0};
        vecs[4]  = '{4'hE, 16'h1234, 3'd4, 1'b0, 1'b0};
        vecs[5]  = '{4'hF, 16'h1234, 3'd4, 1'b0, 1'b1};
        vecs[6]  = '{4'h9, 16'h0009, 3'd1, 1'b0, 1'b0};
        vecs[7]  = '{4'hA, 16'h0009, 3'd1, 1'b0, 1'b0};
        vecs[8]  = '{4'hE, 16'h0000, 3'd0, 1'b0, 1'b0};
        vecs[9]  = '{4'hE, 16'h0000, 3'd0, 1'b0, 1'b0};
        vecs[10] = '{4'h5, 16'h0005, 3'd1, 1'b0, 1'b0};
        vecs[11] = '{4'h6, 16'h0056, 3'd2, 1'b0, 1'b0};
        vecs[12] = '{4'hE, 16'h0005, 3'd1, 1'b0, 1'b0};
        vecs[13] = '{4'h8, 16'h0058, 3'd2, 1'b0, 1'b0};
        vecs[14] = '{4'hE, 16'h0005, 3'd1, 1'b0, 1'b0};
        vecs[15] = '{4'hE, 16'h0000, 3'd0, 1'b0, 1'b0};
        vecs[16] = '{4'hE, 16'h0000, 3'd0, 1'b0, 1'b0};
        lv = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0;
        key   = 4'h0;
        kd    = 1'b0;
        clr   = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Bounce: the pulse must follow the 4th consecutive high sample.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            key = 4'h7;
            kd  = lv[i];
            if (i == 3) push_exp(4'h7, 16'h0007, 3'd1, 1'b0, 1'b0, cyc + DB);
        end
        @(negedge clk);
        kd = 1'b0;
        repeat (8) @(negedge clk);

        // Clear while idle.
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clear_entry", {16'd0, entry}, 32'd0);
        chk("clear_count", {29'd0, dcount}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 17; i++)
            press(vecs[i].key, vecs[i].entry, vecs[i].count, vecs[i].valid, vecs[i].cmd, 1'b0);

        // Clear colliding with the 4th digit's acceptance.
        press(4'h1, 16'h0001, 3'd1, 1'b0, 1'b0, 1'b0);
        press(4'h2, 16'h0012, 3'd2, 1'b0, 1'b0, 1'b0);
        press(4'h3, 16'h0123, 3'd3, 1'b0, 1'b0, 1'b0);
        press(4'h4, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1);
        press(4'h7, 16'h0007, 3'd1, 1'b0, 1'b0, 1'b0);

        // Reset mid-PRESS_DB with the key held; a full requalification must follow.
        @(negedge clk);
        key = 4'h5;
        kd  = 1'b1;
        repeat (2) @(negedge clk);
        chk("busy_in_press", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1 chk_all_zero("midpress_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_exp(4'h5, 16'h0005, 3'd1, 1'b0, 1'b0, cyc + DB);
        repeat (6) @(negedge clk);
        kd = 1'b0;
        repeat (8) @(negedge clk);

        chk("scoreboard_empty", sb.size(), 32'd0);
        chk("final_busy", {31'd0, busy}, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
